// File: rtl/dff_serial_tx.sv
// Framed serial transmitter: start bit, LSB-first data, optional parity, stop bit,
// each bit held for CLKS_PER_BIT clocks on a registered line that idles high.
module dff_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              c,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              d_out,
    output logic              busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_ONE   = CW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic          PAR_SENSE = (PARITY_ODD != 0);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                par_q, par_d;
    logic                d_out_q, d_out_d;
    logic                busy_q, busy_d;
    logic                ready_s;
    logic                accept_s;
    logic                last_cyc_s;

    // Parity is fixed at accept time so the shift register is free to shift.
    function automatic logic parity_of(input logic [DATA_W-1:0] w);
        return (^w) ^ PAR_SENSE;
    endfunction

    // State register with synchronous active-low reset.
    always_ff @(posedge c) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            d_out_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            d_out_q <= d_out_d;
            busy_q  <= busy_d;
        end
    end

    // Ready decode: idle, or the final cycle of the stop bit for back-to-back frames.
    always_comb begin
        ready_s = 1'b0;
        if (state_q == S_IDLE) begin
            ready_s = 1'b1;
        end else if ((state_q == S_STOP) && (cyc_q == CYC_LAST)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign tx_ready = ready_s;

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        accept_s   = tx_valid && ready_s;
        last_cyc_s = (cyc_q == CYC_LAST);

        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                if (accept_s) begin
                    state_d = S_START;
                    shreg_d = tx_data;
                    par_d   = parity_of(tx_data);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (last_cyc_s) begin
                    state_d = S_DATA;
                    cyc_d   = '0;
                    bit_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            S_DATA: begin
                if (last_cyc_s) begin
                    cyc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        shreg_d = shreg_q >> 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            S_PARITY: begin
                if (last_cyc_s) begin
                    state_d = S_STOP;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            S_STOP: begin
                if (last_cyc_s) begin
                    cyc_d = '0;
                    bit_d = '0;
                    if (accept_s) begin
                        state_d = S_START;
                        shreg_d = tx_data;
                        par_d   = parity_of(tx_data);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line level and busy follow the next state so they appear one edge after accept.
    always_comb begin
        d_out_d = 1'b1;
        busy_d  = 1'b1;
        case (state_d)
            S_IDLE: begin
                d_out_d = 1'b1;
                busy_d  = 1'b0;
            end
            S_START:  d_out_d = 1'b0;
            S_DATA:   d_out_d = shreg_d[0];
            S_PARITY: d_out_d = par_d;
            S_STOP:   d_out_d = 1'b1;
            default: begin
                d_out_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign d_out = d_out_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dff_serial_tx.sv
// Scoreboard bench for dff_serial_tx: per-cycle {busy,d_out,tx_ready} samples are
// queued when stimulus is driven and compared one per clock as the line runs.
module tb_dff_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [1:0] sel;
    logic [3:0] rdy;
    logic [3:0] dout;
    logic [3:0] bsy;

    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;
    logic [2:0] mon_obs;
    int         errors    = 0;
    int         checks    = 0;
    int         sample_no = 0;
    string      tag       = "reset";

    always #5 clk = ~clk;

    dff_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .c(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid && (sel == 2'd0)),
        .tx_ready(rdy[0]), .d_out(dout[0]), .busy(bsy[0]));
    dff_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .c(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid && (sel == 2'd1)),
        .tx_ready(rdy[1]), .d_out(dout[1]), .busy(bsy[1]));
    dff_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .c(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid && (sel == 2'd2)),
        .tx_ready(rdy[2]), .d_out(dout[2]), .busy(bsy[2]));
    dff_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
        .c(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid && (sel == 2'd3)),
        .tx_ready(rdy[3]), .d_out(dout[3]), .busy(bsy[3]));

    // One queued sample is compared 1 time unit after every rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_obs = {bsy[sel], dout[sel], rdy[sel]};
            checks++;
            assert (mon_obs === mon_exp) else begin
                errors++;
                $error("FAIL %s sample %0d: observed busy,d_out,tx_ready=%b expected %b",
                       tag, sample_no, mon_obs, mon_exp);
            end
            sample_no++;
        end
    end

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(3'b011);
    endtask

    // Expected frame built from the frame definition; nmax truncates it.
    task automatic push_frame(input logic [7:0] d, input int pen, input int podd,
                              input int cpb, input int nmax);
        logic [10:0] b;
        int nb;
        int idx;
        nb   = 10 + pen;
        b    = 11'd0;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        if (pen != 0) b[9] = (^d) ^ podd[0];
        b[nb-1] = 1'b1;
        idx = 0;
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < cpb; j++) begin
                if (idx < nmax) exp_q.push_back({1'b1, b[k], (idx == nb*cpb - 1)});
                idx++;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s drain: observed %0d samples left, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called at a negedge with the selected DUT idle.
    task automatic send(input logic [7:0] d, input int pen, input int podd,
                        input int cpb, input int idle_after);
        tx_data  = d;
        tx_valid = 1'b1;
        push_frame(d, pen, podd, cpb, 1000);
        push_idle(idle_after);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
        wait_drain();
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        sel      = 2'd0;
        tag      = "reset";
        push_idle(3);
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        push_idle(2);
        repeat (2) @(negedge clk);

        tag = "a5_cpb4";
        send(8'hA5, 0, 0, 4, 2);

        tag = "parity_even_a5";
        sel = 2'd1;
        send(8'hA5, 1, 0, 4, 2);

        tag = "parity_odd_01";
        sel = 2'd2;
        send(8'h01, 1, 1, 4, 2);

        tag = "a5_cpb1";
        sel = 2'd3;
        send(8'hA5, 0, 0, 1, 2);

        tag      = "back_to_back";
        sel      = 2'd0;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        push_frame(8'h00, 0, 0, 4, 1000);
        push_frame(8'hFF, 0, 0, 4, 1000);
        push_idle(4);
        @(negedge clk);
        tx_data = 8'hFF;
        repeat (40) @(negedge clk);
        tx_valid = 1'b0;
        wait_drain();

        tag      = "ignore_midframe";
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        push_frame(8'h5A, 0, 0, 4, 1000);
        push_idle(3);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (15) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        wait_drain();

        tag      = "reset_in_bit3";
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        push_frame(8'h96, 0, 0, 4, 18);
        push_idle(2);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain();

        tag = "send_3c";
        send(8'h3C, 0, 0, 4, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
